// File: rtl/shift_pkg.sv
// Op encoding and bit helpers shared by the shift_pipe entry/exit logic and its stages.
// Rotate ops are decoded only when SHIFT_PIPE_ROTATE_EN is defined.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } shift_op_e;

    localparam int MAX_W = 64;

    function automatic logic is_left(input logic [2:0] op);
`ifdef SHIFT_PIPE_ROTATE_EN
        return (op == OP_SLL) || (op == OP_ROL);
`else
        return op == OP_SLL;
`endif
    endfunction

    function automatic logic op_supported(input logic [2:0] op);
`ifdef SHIFT_PIPE_ROTATE_EN
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
               (op == OP_ROL) || (op == OP_ROR);
`else
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`endif
    endfunction

    // Reverses the low w bits of d; bits at and above w come back zero.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] d, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) r[i] = d[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One pipeline stage: conditional right shift by 2**STAGE (zero/sign/rotate fill); 1-cycle register slice.
// Loads when empty or downstream ready; rotate fill exists only with SHIFT_PIPE_ROTATE_EN.
module shift_pipe_stage
    import shift_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int STAGE = 0,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [2:0]       in_op,
    input  logic             in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_cnt,
    output logic [2:0]       out_op,
    output logic             out_sign
);

    localparam int               SHIFT = 1 << STAGE;
    localparam logic [WIDTH-1:0] ONES  = '1;

    logic             valid_q;
    logic [WIDTH-1:0] data_q, data_d, fill;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic             sign_q;

    assign in_ready = !valid_q || out_ready;

    // Fill occupies exactly the top SHIFT bits vacated by the right shift.
    always_comb begin
        fill = '0;
        if (in_op == OP_SRA && in_sign) fill = ~(ONES >> SHIFT);
`ifdef SHIFT_PIPE_ROTATE_EN
        if (in_op == OP_ROL || in_op == OP_ROR) fill = in_data << (WIDTH - SHIFT);
`endif
        data_d = in_cnt[STAGE] ? ((in_data >> SHIFT) | fill) : in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= data_d;
                cnt_q  <= in_cnt;
                op_q   <= in_op;
                sign_q <= in_sign;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_cnt   = cnt_q;
    assign out_op    = op_q;
    assign out_sign  = sign_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA, ROL/ROR when SHIFT_PIPE_ROTATE_EN); latency CNT_W cycles, 1 op/cycle.
// Per-stage valid/ready slices; in_ready is the only combinational path (from out_ready and stage valids).
module shift_pipe
    import shift_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [CNT_W:0]   vld, rdy, sgn;
    logic [WIDTH-1:0] dat [CNT_W+1];
    logic [CNT_W-1:0] cnt [CNT_W+1];
    logic [2:0]       op  [CNT_W+1];
    logic             unused_tail;

    // Left ops run as right ops on the mirrored operand; unsupported ops get count 0 so they pass through.
    assign vld[0] = in_valid;
    assign in_ready = rdy[0];
    assign dat[0] = is_left(in_op) ? WIDTH'(bit_reverse(MAX_W'(in_data), WIDTH)) : in_data;
    assign cnt[0] = op_supported(in_op) ? in_cnt : '0;
    assign op[0]  = in_op;
    assign sgn[0] = in_data[WIDTH-1];

    for (genvar k = 0; k < CNT_W; k++) begin : g_stage
        shift_pipe_stage #(
            .WIDTH (WIDTH),
            .STAGE (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld[k]),
            .in_ready  (rdy[k]),
            .in_data   (dat[k]),
            .in_cnt    (cnt[k]),
            .in_op     (op[k]),
            .in_sign   (sgn[k]),
            .out_valid (vld[k+1]),
            .out_ready (rdy[k+1]),
            .out_data  (dat[k+1]),
            .out_cnt   (cnt[k+1]),
            .out_op    (op[k+1]),
            .out_sign  (sgn[k+1])
        );
    end

    assign rdy[CNT_W] = out_ready;
    assign out_valid  = vld[CNT_W];
    assign out_data   = is_left(op[CNT_W]) ? WIDTH'(bit_reverse(MAX_W'(dat[CNT_W]), WIDTH))
                                           : dat[CNT_W];
    assign unused_tail = ^{cnt[CNT_W], sgn[CNT_W]};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed-vector and scoreboard bench for shift_pipe at WIDTH=16, with or without SHIFT_PIPE_ROTATE_EN.
module tb_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_cnt = '0;
    logic [2:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

`ifdef SHIFT_PIPE_ROTATE_EN
    localparam logic [15:0] ROR_EXP = 16'h1800;
    localparam logic [15:0] ROL_EXP = 16'h0018;
`else
    localparam logic [15:0] ROR_EXP = 16'h8001;
    localparam logic [15:0] ROL_EXP = 16'h8001;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [15:0] din;
        logic [3:0]  cnt;
        logic [15:0] exp;
    } vec_t;

    vec_t        vt [12];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_out = 0;
    logic [15:0] last_out = '0;
    logic [15:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [2:0] op, input logic [15:0] d,
                                              input logic [3:0] c);
        logic [15:0] r;
        case (op)
            3'b000:  r = d << c;
            3'b001:  r = d >> c;
            3'b010:  r = $signed(d) >>> c;
`ifdef SHIFT_PIPE_ROTATE_EN
            3'b011:  r = (d << c) | (d >> (16 - c));
            3'b100:  r = (d >> c) | (d << (16 - c));
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                last_out = out_data;
                check("sb_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_data", out_data, e);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_shift(in_op, in_data, in_cnt));
        end
    end

    task automatic run_one(input vec_t v, input int idx);
        int c0;
        bit seen;
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = v.op; in_data = v.din; in_cnt = v.cnt; out_ready = 1'b1;
        c0 = cyc;
        @(negedge clk);
        check($sformatf("vec%0d_in_ready", idx), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check($sformatf("vec%0d_timeout", idx), seen, 1);
        check($sformatf("vec%0d_latency", idx), cyc - c0, 4);
        check($sformatf("vec%0d_data", idx), out_data, v.exp);
        @(posedge clk);
    endtask

    initial begin
        int  issued, stall, guard;
        bit  acc, seen;

        vt[0]  = '{3'b001, 16'h8001, 4'd4,  16'h0800};
        vt[1]  = '{3'b010, 16'h8001, 4'd4,  16'hF800};
        vt[2]  = '{3'b010, 16'h7FFF, 4'd15, 16'h0000};
        vt[3]  = '{3'b000, 16'h8001, 4'd1,  16'h0002};
        vt[4]  = '{3'b100, 16'h8001, 4'd4,  ROR_EXP};
        vt[5]  = '{3'b011, 16'h8001, 4'd4,  ROL_EXP};
        vt[6]  = '{3'b111, 16'h8001, 4'd4,  16'h8001};
        vt[7]  = '{3'b010, 16'h8001, 4'd0,  16'h8001};
        vt[8]  = '{3'b000, 16'h0001, 4'd15, 16'h8000};
        vt[9]  = '{3'b001, 16'hFFFF, 4'd8,  16'h00FF};
        vt[10] = '{3'b101, 16'h1234, 4'd3,  16'h1234};
        vt[11] = '{3'b010, 16'hF0F0, 4'd15, 16'hFFFF};

        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 16'h0000);
        #9 rst_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 12; i++) run_one(vt[i], i);

        // Back-pressure: fill the pipe with out_ready low, then release.
        n_out = 0; issued = 0; stall = 0; guard = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        while (issued < 6 && guard < 60) begin
            guard++;
            in_valid = 1'b1;
            in_op = 3'(issued % 3);
            in_data = 16'(16'h1111 * (issued + 1));
            in_cnt = 4'(issued + 1);
            @(negedge clk);
            acc = in_ready;
            if (!acc) begin
                stall++;
                if (stall == 3) begin
                    check("bp_in_ready_low", in_ready, 0);
                    check("bp_held_count", issued, 4);
                    check("bp_no_output", n_out, 0);
                    check("bp_out_valid", out_valid, 1);
                end
            end
            @(posedge clk); #1;
            if (acc) issued++;
            if (stall >= 3 && !out_ready) begin
                out_ready = 1'b1;
                #1 check("bp_full_pipe_ready", in_ready, 1);
            end
        end
        in_valid = 1'b0;
        check("bp_issued", issued, 6);
        for (int i = 0; i < 40 && n_out < 6; i++) @(posedge clk);
        #1 check("bp_out_count", n_out, 6);

        // Random valid/ready traffic against the reference model.
        acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_op = 3'($urandom_range(0, 7));
                in_data = 16'($urandom);
                in_cnt = 4'($urandom_range(0, 15));
            end
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            acc = in_valid && in_ready;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) @(posedge clk);
        #1 check("rand_drain", exp_q.size(), 0);

        // Reset with three ops in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_op = 3'b001; in_data = 16'(16'hA5A5 + i); in_cnt = 4'd2;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rst_mid_fill", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_data", out_data, 16'h0000);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        #1 check("rst_mid_in_ready", in_ready, 1);
        n_out = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = 3'b010; in_data = 16'h8001; in_cnt = 4'd4; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("rst_new_count", n_out, 1);
        check("rst_new_result", last_out, 16'hF800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
